// File: rtl/param_data_stack.sv
// Parametrised operand stack: top/second held in registers for zero-latency ALU access,
// deeper entries spill to a LIFO array. Reports occupancy and sticky overflow/underflow.
module param_data_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top_of_stack,
  output logic [WIDTH-1:0] second_of_stack,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned MemDepth = DEPTH - 2;
  localparam int unsigned AW       = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpPush    = 3'b001;
  localparam logic [2:0] OpDrop    = 3'b010;
  localparam logic [2:0] OpDup     = 3'b011;
  localparam logic [2:0] OpOver    = 3'b100;
  localparam logic [2:0] OpSwap    = 3'b101;
  localparam logic [2:0] OpBinop   = 3'b110;
  localparam logic [2:0] OpReplace = 3'b111;

  localparam logic [1:0] ErrOverflow  = 2'b01;
  localparam logic [1:0] ErrUnderflow = 2'b10;

  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [WIDTH-1:0] mem [MemDepth];
  logic [AW-1:0]    spill_idx;
  logic [AW-1:0]    head_idx;
  logic [WIDTH-1:0] head;
  logic             spill_en;

  logic             full_w;
  logic             empty_w;
  logic             ge2;
  logic             legal;
  logic             grow;
  logic [WIDTH-1:0] push_val;

  assign full_w  = (depth_q == CW'(DEPTH));
  assign empty_w = (depth_q == '0);
  assign ge2     = (depth_q >= CW'(2));

  // Array write pointer is depth-2; entry 2 (array head) sits one below it.
  assign spill_idx = AW'(depth_q - CW'(2));
  assign head_idx  = AW'(depth_q - CW'(3));
  assign head      = (depth_q >= CW'(3)) ? mem[head_idx] : '0;

  // Precondition check and push source selection.
  always_comb begin
    legal    = 1'b1;
    grow     = 1'b0;
    push_val = din;
    unique case (op)
      OpNop:     legal = 1'b1;
      OpPush:    begin legal = !full_w;             grow = 1'b1; push_val = din;      end
      OpDrop:    legal = !empty_w;
      OpDup:     begin legal = !empty_w && !full_w; grow = 1'b1; push_val = top_q;    end
      OpOver:    begin legal = ge2 && !full_w;      grow = 1'b1; push_val = second_q; end
      OpSwap:    legal = ge2;
      OpBinop:   legal = ge2;
      OpReplace: legal = !empty_w;
      default:   legal = 1'b1;
    endcase
  end

  always_comb begin
    top_d    = top_q;
    second_d = second_q;
    depth_d  = depth_q;
    err_d    = err_q;
    code_d   = code_q;
    spill_en = 1'b0;

    if (op_valid && legal) begin
      if (grow) begin
        top_d    = push_val;
        second_d = top_q;
        depth_d  = depth_q + CW'(1);
        spill_en = ge2;
      end else begin
        unique case (op)
          OpDrop: begin
            top_d    = second_q;
            second_d = head;
            depth_d  = depth_q - CW'(1);
          end
          OpSwap: begin
            top_d    = second_q;
            second_d = top_q;
          end
          OpBinop: begin
            top_d    = din;
            second_d = head;
            depth_d  = depth_q - CW'(1);
          end
          OpReplace: top_d = din;
          default: ;
        endcase
      end
    end

    // A rejected op beats clear_err; otherwise the first recorded code is kept.
    if (op_valid && !legal) begin
      err_d = 1'b1;
      if (clear_err || (code_q == 2'b00)) begin
        code_d = (grow && full_w) ? ErrOverflow : ErrUnderflow;
      end
    end else if (clear_err) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      top_q    <= '0;
      second_q <= '0;
      depth_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      top_q    <= top_d;
      second_q <= second_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Spill storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (spill_en) begin
      mem[spill_idx] <= second_q;
    end
  end

  assign top_of_stack    = top_q;
  assign second_of_stack = second_q;
  assign depth           = depth_q;
  assign empty           = empty_w;
  assign full            = full_w;
  assign err             = err_q;
  assign err_code        = code_q;

endmodule

// File: tb/tb_param_data_stack.sv
// Scoreboard bench for param_data_stack: driver predicts with a queue-based stack model,
// monitor compares every clocked update and every asynchronous reset.
module tb_param_data_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] Nop = 3'd0, Push = 3'd1, Drop = 3'd2, Dup = 3'd3;
  localparam logic [2:0] Over = 3'd4, Swap = 3'd5, Binop = 3'd6, Repl = 3'd7;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       op = '0;
  logic             op_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] top_of_stack, second_of_stack;
  logic [CW-1:0]    depth;
  logic             empty, full, err;
  logic [1:0]       err_code;

  param_data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .op              (op),
    .op_valid        (op_valid),
    .din             (din),
    .clear_err       (clear_err),
    .top_of_stack    (top_of_stack),
    .second_of_stack (second_of_stack),
    .depth           (depth),
    .empty           (empty),
    .full            (full),
    .err             (err),
    .err_code        (err_code)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] sec;
    int unsigned      dep;
    logic             err;
    logic [1:0]       code;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model[$];   // index 0 is the top of stack
  logic             m_err;
  logic [1:0]       m_code;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.top  = (model.size() >= 1) ? model[0] : '0;
    e.sec  = (model.size() >= 2) ? model[1] : '0;
    e.dep  = model.size();
    e.err  = m_err;
    e.code = m_code;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [2:0] o, input logic v, input logic [WIDTH-1:0] d,
                            input logic c);
    int unsigned      n = model.size();
    bit               ok;
    bit               grows;
    logic [WIDTH-1:0] t;
    grows = (o == Push) || (o == Dup) || (o == Over);
    case (o)
      Nop:         ok = 1;
      Push:        ok = n < DEPTH;
      Drop:        ok = n >= 1;
      Dup:         ok = (n >= 1) && (n < DEPTH);
      Over:        ok = (n >= 2) && (n < DEPTH);
      Swap, Binop: ok = n >= 2;
      default:     ok = n >= 1;
    endcase
    if (v && ok) begin
      case (o)
        Push: model.push_front(d);
        Drop: void'(model.pop_front());
        Dup:  model.push_front(model[0]);
        Over: model.push_front(model[1]);
        Swap: begin t = model[0]; model[0] = model[1]; model[1] = t; end
        Binop: begin
          void'(model.pop_front());
          void'(model.pop_front());
          model.push_front(d);
        end
        Repl: model[0] = d;
        default: ;
      endcase
    end
    if (v && !ok) begin
      m_err = 1'b1;
      if (c || m_code == 2'b00) m_code = (grows && n == DEPTH) ? 2'b01 : 2'b10;
    end else if (c) begin
      m_err  = 1'b0;
      m_code = 2'b00;
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic v, input logic [WIDTH-1:0] d,
                       input logic c);
    @(negedge CLK);
    op = o; op_valid = v; din = d; clear_err = c;
    model_step(o, v, d, c);
    push_exp();
  endtask

  // Assert reset between edges; the monitor checks the reset state right away.
  task automatic pulse_reset();
    @(negedge CLK);
    op_valid = 1'b0; clear_err = 1'b0;
    #2;
    model.delete();
    m_err = 1'b0; m_code = 2'b00;
    push_exp();
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("top_of_stack", 32'(top_of_stack), 32'(e.top));
        check("second_of_stack", 32'(second_of_stack), 32'(e.sec));
        check("depth", 32'(depth), e.dep);
        check("empty", 32'(empty), 32'(e.dep == 0));
        check("full", 32'(full), 32'(e.dep == DEPTH));
        check("err", 32'(err), 32'(e.err));
        check("err_code", 32'(err_code), 32'(e.code));
      end
    end
  end

  initial begin : driver
    logic [2:0] o;
    #2;
    model.delete();
    m_err = 1'b0; m_code = 2'b00;
    push_exp();
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;

    do_op(Push, 1, 16'd2, 0);
    do_op(Push, 1, 16'd4096, 0);

    pulse_reset();
    do_op(Push, 1, 16'd1, 0); do_op(Push, 1, 16'd2, 0); do_op(Push, 1, 16'd3, 0);
    do_op(Binop, 1, 16'd5, 0);

    pulse_reset();
    do_op(Push, 1, 16'd1, 0); do_op(Push, 1, 16'd2, 0);
    do_op(Over, 1, 16'hdead, 0); do_op(Dup, 1, 16'hbeef, 0);
    pulse_reset();
    do_op(Push, 1, 16'd1, 0); do_op(Push, 1, 16'd2, 0); do_op(Push, 1, 16'd3, 0);
    do_op(Swap, 1, 16'd0, 0); do_op(Drop, 1, 16'd0, 0);
    do_op(Repl, 1, 16'h77, 0); do_op(Nop, 1, 16'h55, 0); do_op(Push, 0, 16'h99, 0);

    pulse_reset();
    do_op(Drop, 1, 16'd0, 0);
    do_op(Swap, 1, 16'd0, 0);
    do_op(Push, 1, 16'd7, 1);
    do_op(Over, 1, 16'd0, 0);
    do_op(Dup, 1, 16'd0, 1);

    // Overfill, drain past empty, then reset in the middle of refilling.
    pulse_reset();
    for (int i = 0; i < 40; i++) do_op(Push, 1, WIDTH'(i * 3 + 7), 0);
    do_op(Dup, 1, 16'd0, 0);
    do_op(Over, 1, 16'd0, 1);
    for (int i = 0; i < 40; i++) do_op(Drop, 1, 16'd0, 0);
    for (int i = 0; i < 10; i++) do_op(Push, 1, WIDTH'($urandom), 0);
    pulse_reset();
    for (int i = 0; i < 3; i++) do_op(Push, 1, WIDTH'($urandom), 0);

    // Random phases alternately biased toward growth and shrinkage.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) pulse_reset();
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) o = ((i / 150) % 2 == 0) ? Push : Drop;
      do_op(o, ($urandom_range(0, 9) != 0), WIDTH'($urandom), ($urandom_range(0, 15) == 0));
    end

    @(negedge CLK);
    op_valid = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
